// File: rtl/issue_scoreboard.sv
// ID-stage issue controller: per-register countdown scoreboard plus control-transfer sequencing.
// Define ISSUE_SCOREBOARD_FORWARD_EN when an EX/MEM bypass exists.
module issue_scoreboard #(
    parameter int unsigned LAT_ALU  = 2,
    parameter int unsigned LAT_LOAD = 3,
    parameter int unsigned CNT_W    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  id_rd,
    input  logic        id_reg_write,
    input  logic        id_is_load,
    input  logic        id_is_ctrl,
    input  logic        ex_resolved,
    input  logic        ex_redirect,
    output logic        stall,
    output logic        issue_nop,
    output logic        flush_if,
    output logic        issue,
    output logic [31:0] busy_mask
);

    typedef enum logic [1:0] {StIdle, StWaitRes, StFlush} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] timer_q [1:31];
    logic [CNT_W-1:0] timer_d [1:31];
    logic [31:0]      hz_vec;
    logic             raw_hz;
    logic             arm;
    logic [CNT_W-1:0] arm_lat;

`ifdef ISSUE_SCOREBOARD_FORWARD_EN
    // With the bypass, any live timer blocks; only loads arm one.
    localparam logic [CNT_W-1:0] HzMin = '0;
    assign arm     = issue && id_reg_write && id_is_load;
    assign arm_lat = CNT_W'(1);
`else
    // A timer of 1 is the write-back cycle; the register file writes through, so it does not block.
    localparam logic [CNT_W-1:0] HzMin = CNT_W'(1);
    assign arm     = issue && id_reg_write;
    assign arm_lat = id_is_load ? CNT_W'(LAT_LOAD) : CNT_W'(LAT_ALU);
`endif

    always_comb begin
        hz_vec    = '0;
        busy_mask = '0;
        for (int i = 1; i < 32; i++) begin
            hz_vec[i]    = timer_q[i] > HzMin;
            busy_mask[i] = timer_q[i] != '0;
        end
    end

    assign raw_hz = (id_uses_rs1 && hz_vec[id_rs1]) || (id_uses_rs2 && hz_vec[id_rs2]);

    // Outputs are forced low while reset is held; issue_nop only marks a held instruction.
    assign stall     = !reset && id_valid && (raw_hz || state_q != StIdle);
    assign issue     = !reset && id_valid && !stall;
    assign issue_nop = !reset && id_valid && !issue;
    assign flush_if  = (state_q == StFlush);

    always_comb begin
        logic [CNT_W-1:0] dec;
        dec = '0;
        for (int i = 1; i < 32; i++) begin
            dec = (timer_q[i] != '0) ? timer_q[i] - CNT_W'(1) : '0;
            // Max rule keeps a younger, faster write from hiding an older, slower one.
            timer_d[i] = (arm && id_rd == 5'(i) && arm_lat > dec) ? arm_lat : dec;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < 32; i++) timer_q[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) timer_q[i] <= timer_d[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:    if (issue && id_is_ctrl) state_q <= StWaitRes;
                StWaitRes: if (ex_resolved) state_q <= ex_redirect ? StFlush : StIdle;
                StFlush:   state_q <= StIdle;
                default:   state_q <= StIdle;
            endcase
        end
    end

endmodule
